phase_timer_sequencer: RTL and testbench



---
 rtl/phase_timer_sequencer.sv | 171 +++++++++++++++++
 tb/tb_phase_timer_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_timer_sequencer.sv
// phase_timer_sequencer: two-approach intersection phase controller.
// Six phases (A green, A yellow, all-red, B green, B yellow, all-red) share
// one down-counter. A green may be extended while its own approach keeps
// demanding, and it rests at timer==0 while the other approach has no request.
// Optional macro SENSE_SYNC_EN: when defined, sense_a/sense_b pass through
// 2-flop synchronizers before request latching and extension checks.
module phase_timer_sequencer #(
  parameter int CNT_W    = 8,
  parameter int GREEN_T  = 20,
  parameter int YELLOW_T = 4,
  parameter int ALLRED_T = 2,
  parameter int EXT_T    = 5,
  parameter int MAX_EXT  = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             hold,
  input  logic             sense_a,
  input  logic             sense_b,
  output logic [2:0]       lamp_a,
  output logic [2:0]       lamp_b,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] timer,
  output logic [1:0]       ext_cnt
);

  localparam logic [2:0] A_GRN  = 3'd0;
  localparam logic [2:0] A_YEL  = 3'd1;
  localparam logic [2:0] RED_AB = 3'd2;
  localparam logic [2:0] B_GRN  = 3'd3;
  localparam logic [2:0] B_YEL  = 3'd4;
  localparam logic [2:0] RED_BA = 3'd5;

  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] EXT_LD    = CNT_W'(EXT_T - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [1:0]       EXT_MAX   = 2'(MAX_EXT);

  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;

  logic [2:0]       phase_q, phase_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [1:0]       ext_q, ext_d;
  logic             req_a_q, req_a_d, req_b_q, req_b_d;
  logic [2:0]       lamp_a_q, lamp_a_d, lamp_b_q, lamp_b_d;
  logic             sa, sb;

`ifdef SENSE_SYNC_EN
  logic [1:0] sync_a_q, sync_b_q;

  // Two-flop synchronizers on the raw sensor inputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_a_q <= '0;
      sync_b_q <= '0;
    end else if (clr) begin
      sync_a_q <= '0;
      sync_b_q <= '0;
    end else begin
      sync_a_q <= {sync_a_q[0], sense_a};
      sync_b_q <= {sync_b_q[0], sense_b};
    end
  end

  assign sa = sync_a_q[1];
  assign sb = sync_b_q[1];
`else
  assign sa = sense_a;
  assign sb = sense_b;
`endif

  // Next phase/timer/extension count, request latches and lamp decode
  always_comb begin
    phase_d = phase_q;
    timer_d = timer_q;
    ext_d   = ext_q;
    if (phase_q > RED_BA) begin
      // Illegal encoding: recover to the all-red clearance before A
      phase_d = RED_BA;
      timer_d = ALLRED_LD;
      ext_d   = 2'd0;
    end else if (!hold) begin
      if (timer_q != '0) begin
        timer_d = timer_q - ONE;
      end else begin
        case (phase_q)
          A_GRN: begin
            if (req_b_q && sa && ext_q < EXT_MAX) begin
              timer_d = EXT_LD;
              ext_d   = ext_q + 2'd1;
            end else if (req_b_q) begin
              phase_d = A_YEL;
              timer_d = YELLOW_LD;
            end
          end
          A_YEL:  begin phase_d = RED_AB; timer_d = ALLRED_LD; end
          RED_AB: begin phase_d = B_GRN;  timer_d = GREEN_LD; ext_d = 2'd0; end
          B_GRN: begin
            if (req_a_q && sb && ext_q < EXT_MAX) begin
              timer_d = EXT_LD;
              ext_d   = ext_q + 2'd1;
            end else if (req_a_q) begin
              phase_d = B_YEL;
              timer_d = YELLOW_LD;
            end
          end
          B_YEL:  begin phase_d = RED_BA; timer_d = ALLRED_LD; end
          default: begin phase_d = A_GRN; timer_d = GREEN_LD; ext_d = 2'd0; end
        endcase
      end
    end

    // Demand latches set while that approach is not green; green entry clears
    req_a_d = req_a_q | (sa && phase_q != A_GRN);
    req_b_d = req_b_q | (sb && phase_q != B_GRN);
    if (phase_d == A_GRN && phase_q != A_GRN) req_a_d = 1'b0;
    if (phase_d == B_GRN && phase_q != B_GRN) req_b_d = 1'b0;

    // Lamps follow the next phase so they switch on the same edge as phase
    lamp_a_d = L_RED;
    lamp_b_d = L_RED;
    case (phase_d)
      A_GRN: lamp_a_d = L_GRN;
      A_YEL: lamp_a_d = L_YEL;
      B_GRN: lamp_b_d = L_GRN;
      B_YEL: lamp_b_d = L_YEL;
      default: ;
    endcase
  end

  // State registers; reset and clear both park in the clearance before A
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase_q  <= RED_BA;
      timer_q  <= ALLRED_LD;
      ext_q    <= 2'd0;
      req_a_q  <= 1'b0;
      req_b_q  <= 1'b0;
      lamp_a_q <= L_RED;
      lamp_b_q <= L_RED;
    end else if (clr) begin
      phase_q  <= RED_BA;
      timer_q  <= ALLRED_LD;
      ext_q    <= 2'd0;
      req_a_q  <= 1'b0;
      req_b_q  <= 1'b0;
      lamp_a_q <= L_RED;
      lamp_b_q <= L_RED;
    end else begin
      phase_q  <= phase_d;
      timer_q  <= timer_d;
      ext_q    <= ext_d;
      req_a_q  <= req_a_d;
      req_b_q  <= req_b_d;
      lamp_a_q <= lamp_a_d;
      lamp_b_q <= lamp_b_d;
    end
  end

  assign phase   = phase_q;
  assign timer   = timer_q;
  assign ext_cnt = ext_q;
  assign lamp_a  = lamp_a_q;
  assign lamp_b  = lamp_b_q;

endmodule

// File: tb/tb_phase_timer_sequencer.sv
// Bench for phase_timer_sequencer: directed literal checks that pin the
// reference model, then randomized sensor/hold/clear traffic compared
// against the model on every clock.
module tb_phase_timer_sequencer;

  localparam int CNT_W = 8, GREEN_T = 20, YELLOW_T = 4, ALLRED_T = 2;
  localparam int EXT_T = 5, MAX_EXT = 3;
`ifdef SENSE_SYNC_EN
  localparam bit SYNC = 1'b1;
  localparam int SL = 2;
`else
  localparam bit SYNC = 1'b0;
  localparam int SL = 0;
`endif

  logic clock, reset, clr, hold, sense_a, sense_b;
  logic [2:0] lamp_a, lamp_b, phase;
  logic [CNT_W-1:0] timer;
  logic [1:0] ext_cnt;

  int errs = 0, checks = 0;
  bit run = 0;

  phase_timer_sequencer #(.CNT_W(CNT_W), .GREEN_T(GREEN_T), .YELLOW_T(YELLOW_T),
    .ALLRED_T(ALLRED_T), .EXT_T(EXT_T), .MAX_EXT(MAX_EXT)) dut (
    .clock(clock), .reset(reset), .clr(clr), .hold(hold),
    .sense_a(sense_a), .sense_b(sense_b), .lamp_a(lamp_a), .lamp_b(lamp_b),
    .phase(phase), .timer(timer), .ext_cnt(ext_cnt));

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  // Reference model: phase index 0..5 walking a duration table
  typedef struct packed {
    int p; int rem; int ext;
    bit ra; bit rb;
    bit [1:0] pa; bit [1:0] pb;
  } mstate_t;

  mstate_t m;

  function automatic int dur(int p);
    case (p % 3)
      0: return GREEN_T;
      1: return YELLOW_T;
      default: return ALLRED_T;
    endcase
  endfunction

  function automatic mstate_t rst_state();
    mstate_t s;
    s = '0;
    s.p = 5;
    s.rem = ALLRED_T - 1;
    return s;
  endfunction

  function automatic mstate_t step(mstate_t s, bit sa_in, bit sb_in, bit c, bit h);
    mstate_t n;
    bit ea, eb, other, own;
    if (c) return rst_state();
    ea = SYNC ? s.pa[1] : sa_in;
    eb = SYNC ? s.pb[1] : sb_in;
    n = s;
    n.pa = {s.pa[0], sa_in};
    n.pb = {s.pb[0], sb_in};
    if (!h) begin
      if (s.rem > 0) n.rem = s.rem - 1;
      else if (s.p == 0 || s.p == 3) begin
        other = (s.p == 0) ? s.rb : s.ra;
        own   = (s.p == 0) ? ea : eb;
        if (other && own && s.ext < MAX_EXT) begin
          n.rem = EXT_T - 1;
          n.ext = s.ext + 1;
        end else if (other) begin
          n.p = s.p + 1;
          n.rem = dur(n.p) - 1;
        end
      end else begin
        n.p = (s.p + 1) % 6;
        n.rem = dur(n.p) - 1;
        if (n.p == 0 || n.p == 3) n.ext = 0;
      end
    end
    n.ra = s.ra | (ea && s.p != 0);
    n.rb = s.rb | (eb && s.p != 3);
    if (n.p == 0 && s.p != 0) n.ra = 0;
    if (n.p == 3 && s.p != 3) n.rb = 0;
    return n;
  endfunction

  function automatic int lamp_of(int p, int g);
    if (p == g) return 1;
    if (p == g + 1) return 2;
    return 4;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) m <= rst_state();
    else m <= step(m, sense_a, sense_b, clr, hold);
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clock) begin
    if (run && !reset) begin
      checks++;
      if (phase !== 3'(m.p) || timer !== CNT_W'(m.rem) || ext_cnt !== 2'(m.ext) ||
          lamp_a !== 3'(lamp_of(m.p, 0)) || lamp_b !== 3'(lamp_of(m.p, 3))) begin
        errs++;
        $display("FAIL model t=%0t got ph=%0d tm=%0d ext=%0d la=%b lb=%b need ph=%0d tm=%0d ext=%0d la=%b lb=%b",
                 $time, phase, timer, ext_cnt, lamp_a, lamp_b, m.p, m.rem, m.ext,
                 3'(lamp_of(m.p, 0)), 3'(lamp_of(m.p, 3)));
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s got=%0d need=%0d t=%0t", name, got, exp, $time);
    end
  endtask

  // One clock, inputs then change 2 units after the edge
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_phase"}, phase, 5);
    chk({tag, "_timer"}, timer, ALLRED_T - 1);
    chk({tag, "_ext"}, ext_cnt, 0);
    chk({tag, "_lamp_a"}, lamp_a, 4);
    chk({tag, "_lamp_b"}, lamp_b, 4);
  endtask

  initial begin
    reset = 1; clr = 0; hold = 0; sense_a = 0; sense_b = 0;
    cyc(2);
    chk_reset_state("reset");
    run = 1;
    reset = 0;

    // Clearance lasts 2 cycles, then A green
    cyc();
    chk("rba_t0_phase", phase, 5);
    chk("rba_t0_timer", timer, 0);
    cyc();
    chk("agrn_phase", phase, 0);
    chk("agrn_timer", timer, GREEN_T - 1);
    chk("agrn_lamp_a", lamp_a, 1);
    chk("agrn_lamp_b", lamp_b, 4);
    cyc(GREEN_T - 1);
    chk("agrn_end_timer", timer, 0);
    cyc(5);
    chk("rest_phase", phase, 0);
    chk("rest_timer", timer, 0);

    // Demand on B leaves the resting green
    sense_b = 1;
    cyc();
    sense_b = 0;
    cyc(1 + SL);
    chk("ayel_phase", phase, 1);
    chk("ayel_timer", timer, YELLOW_T - 1);
    chk("ayel_lamp_a", lamp_a, 2);

    // Hold freezes yellow at timer 2
    cyc();
    chk("hold_pre_timer", timer, 2);
    hold = 1;
    cyc(10);
    chk("hold_timer", timer, 2);
    chk("hold_phase", phase, 1);
    hold = 0;
    cyc(2);
    chk("post_hold_phase", phase, 1);
    cyc();
    chk("rab_phase", phase, 2);
    chk("rab_lamp_a", lamp_a, 4);
    chk("rab_lamp_b", lamp_b, 4);
    cyc(2);
    chk("bgrn_phase", phase, 3);
    chk("bgrn_lamp_b", lamp_b, 1);
    chk("bgrn_lamp_a", lamp_a, 4);

    // Asynchronous reset mid B green
    cyc(3);
    reset = 1;
    #1;
    chk_reset_state("async");
    cyc();
    reset = 0;

    // Synchronous clear from A green
    cyc(2 + 4);
    chk("pre_clr_phase", phase, 0);
    clr = 1;
    cyc();
    clr = 0;
    chk_reset_state("clr");

    // Extensions: A keeps demanding while B waits
    cyc(2);
    chk("g0_phase", phase, 0);
    sense_a = 1; sense_b = 1;
    cyc();
    sense_b = 0;
    cyc(19);
    chk("ext1_cnt", ext_cnt, 1);
    chk("ext1_timer", timer, EXT_T - 1);
    cyc(10);
    chk("ext3_cnt", ext_cnt, 3);
    chk("ext3_timer", timer, EXT_T - 1);
    cyc(4);
    chk("ext_last_phase", phase, 0);
    chk("ext_last_timer", timer, 0);
    cyc();
    chk("ext_yel_phase", phase, 1);
    chk("ext_yel_timer", timer, YELLOW_T - 1);
    sense_a = 0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      sense_a = ($urandom_range(0, 7) == 0);
      sense_b = ($urandom_range(0, 7) == 0);
      hold    = ($urandom_range(0, 15) == 0);
      clr     = ($urandom_range(0, 399) == 0);
      cyc();
    end
    clr = 0; hold = 0; sense_a = 0; sense_b = 0;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
